// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - control/status bundle between datapath and multicycle sequencer
interface multicycle_sequencer_if;
    logic        start;
    logic        halt_req;
    logic [3:0]  opcode;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_rd;
    logic        ir_load;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        dmem_rd;
    logic        dmem_wr;
    logic        rf_we;
    logic        busy;
    logic        illegal;
    logic [2:0]  state;
    logic [15:0] instr_cnt;

    modport master (
        output start, halt_req, opcode, zero, imem_ready, dmem_ready,
        input  imem_rd, ir_load, pc_en, pc_sel, dmem_rd, dmem_wr, rf_we,
               busy, illegal, state, instr_cnt
    );

    modport slave (
        input  start, halt_req, opcode, zero, imem_ready, dmem_ready,
        output imem_rd, ir_load, pc_en, pc_sel, dmem_rd, dmem_wr, rf_we,
               busy, illegal, state, instr_cnt
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - fetch/decode/exec/mem/wb control FSM with retire counter
module multicycle_sequencer (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_instr_cnt;
    logic        r_illegal;

    logic w_is_lw, w_is_sw, w_is_alu, w_is_beq, w_is_bne, w_is_jmp, w_is_ill;
    logic w_imem_rd, w_ir_load, w_pc_en, w_dmem_rd, w_dmem_wr, w_rf_we;
    logic [1:0] w_pc_sel;
    logic w_retire, w_set_illegal, w_clr_illegal;

    always_comb begin
        w_is_lw  = 1'b0;
        w_is_sw  = 1'b0;
        w_is_alu = 1'b0;
        w_is_beq = 1'b0;
        w_is_bne = 1'b0;
        w_is_jmp = 1'b0;
        w_is_ill = 1'b0;
        case (bus.opcode)
            4'b0000: w_is_lw  = 1'b1;
            4'b0001: w_is_sw  = 1'b1;
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1001: w_is_alu = 1'b1;
            4'b1011: w_is_beq = 1'b1;
            4'b1100: w_is_bne = 1'b1;
            4'b1101: w_is_jmp = 1'b1;
            default: w_is_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_next_state  = r_state;
        w_imem_rd     = 1'b0;
        w_ir_load     = 1'b0;
        w_pc_en       = 1'b0;
        w_pc_sel      = 2'b00;
        w_dmem_rd     = 1'b0;
        w_dmem_wr     = 1'b0;
        w_rf_we       = 1'b0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_clr_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_imem_rd = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_load    = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_is_alu) begin
                    w_next_state = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_next_state = S_MEM;
                end else if (w_is_beq) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = bus.zero ? 2'b01 : 2'b00;
                    w_retire = 1'b1;
                end else if (w_is_bne) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = bus.zero ? 2'b00 : 2'b01;
                    w_retire = 1'b1;
                end else if (w_is_jmp) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = 2'b10;
                    w_retire = 1'b1;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next_state  = S_HALT;
                end
            end
            S_MEM: begin
                // Opcode is held stable through MEM, so it still selects read vs write
                w_dmem_rd = w_is_lw;
                w_dmem_wr = w_is_sw;
                if (bus.dmem_ready) begin
                    if (w_is_sw) begin
                        w_pc_en  = 1'b1;
                        w_retire = 1'b1;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_we  = 1'b1;
                w_pc_en  = 1'b1;
                w_retire = 1'b1;
            end
            S_HALT: begin
                if (bus.start) begin
                    w_clr_illegal = 1'b1;
                    w_next_state  = S_FETCH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_retire) w_next_state = bus.halt_req ? S_HALT : S_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_instr_cnt <= 16'h0000;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) r_instr_cnt <= r_instr_cnt + 16'd1;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end else if (w_clr_illegal) begin
                r_illegal <= 1'b0;
            end
        end
    end

    assign bus.imem_rd   = w_imem_rd;
    assign bus.ir_load   = w_ir_load;
    assign bus.pc_en     = w_pc_en;
    assign bus.pc_sel    = w_pc_sel;
    assign bus.dmem_rd   = w_dmem_rd;
    assign bus.dmem_wr   = w_dmem_wr;
    assign bus.rf_we     = w_rf_we;
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.illegal   = r_illegal;
    assign bus.state     = r_state;
    assign bus.instr_cnt = r_instr_cnt;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed vector bench for multicycle_sequencer
module tb_multicycle_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_sequencer_if bus();

    multicycle_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        logic        start;
        logic        halt_req;
        logic [3:0]  opcode;
        logic        zero;
        logic        imem_ready;
        logic        dmem_ready;
        logic [12:0] exp_out;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic logic [12:0] o(input logic [2:0] st, input logic imem, input logic irl,
                                      input logic pce, input logic [1:0] ps, input logic dr,
                                      input logic dw, input logic we, input logic bsy,
                                      input logic ill);
        return {st, imem, irl, pce, ps, dr, dw, we, bsy, ill};
    endfunction

    function automatic logic [12:0] act_out();
        return {bus.state, bus.imem_rd, bus.ir_load, bus.pc_en, bus.pc_sel, bus.dmem_rd,
                bus.dmem_wr, bus.rf_we, bus.busy, bus.illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic hr, input logic [3:0] op, input logic z,
                         input logic ir, input logic dr);
        bus.start      = s;
        bus.halt_req   = hr;
        bus.opcode     = op;
        bus.zero       = z;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 4'h2, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wb_cyc;
        int rd_cycles;
        logic wb_we;

        drive(0, 0, 4'h2, 0, 0, 0);
        #2;
        check("reset_outputs", act_out(), 13'h0);
        check("reset_cnt", bus.instr_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //              s  hr op     z  ir dr   st imem irl pce ps    dr dw we bsy ill  cnt
        vq.push_back('{0, 0, 4'h2, 0, 0, 0, o(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0), 16'd0});
        vq.push_back('{1, 0, 4'h2, 0, 0, 0, o(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0), 16'd0});
        vq.push_back('{0, 0, 4'h2, 0, 1, 0, o(1, 1, 1, 0, 2'd0, 0, 0, 0, 1, 0), 16'd0});
        vq.push_back('{0, 0, 4'h2, 0, 0, 0, o(2, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd0});
        vq.push_back('{0, 0, 4'h2, 0, 0, 0, o(3, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd0});
        vq.push_back('{0, 0, 4'h2, 0, 0, 0, o(5, 0, 0, 1, 2'd0, 0, 0, 1, 1, 0), 16'd0});
        vq.push_back('{0, 0, 4'hB, 1, 0, 0, o(1, 1, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd1});
        vq.push_back('{0, 0, 4'hB, 1, 1, 0, o(1, 1, 1, 0, 2'd0, 0, 0, 0, 1, 0), 16'd1});
        vq.push_back('{1, 0, 4'hB, 1, 0, 0, o(2, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd1});
        vq.push_back('{0, 0, 4'hB, 1, 0, 0, o(3, 0, 0, 1, 2'd1, 0, 0, 0, 1, 0), 16'd1});
        vq.push_back('{0, 0, 4'hC, 1, 1, 0, o(1, 1, 1, 0, 2'd0, 0, 0, 0, 1, 0), 16'd2});
        vq.push_back('{0, 0, 4'hC, 1, 0, 0, o(2, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd2});
        vq.push_back('{0, 0, 4'hC, 1, 0, 0, o(3, 0, 0, 1, 2'd0, 0, 0, 0, 1, 0), 16'd2});
        vq.push_back('{0, 1, 4'hD, 0, 1, 0, o(1, 1, 1, 0, 2'd0, 0, 0, 0, 1, 0), 16'd3});
        vq.push_back('{0, 1, 4'hD, 0, 0, 0, o(2, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd3});
        vq.push_back('{0, 0, 4'hD, 0, 0, 0, o(3, 0, 0, 1, 2'd2, 0, 0, 0, 1, 0), 16'd3});
        vq.push_back('{0, 0, 4'h1, 0, 1, 0, o(1, 1, 1, 0, 2'd0, 0, 0, 0, 1, 0), 16'd4});
        vq.push_back('{0, 0, 4'h1, 0, 0, 0, o(2, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd4});
        vq.push_back('{0, 0, 4'h1, 0, 0, 1, o(3, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd4});
        vq.push_back('{0, 0, 4'h1, 0, 0, 0, o(4, 0, 0, 0, 2'd0, 0, 1, 0, 1, 0), 16'd4});
        vq.push_back('{0, 1, 4'h1, 0, 0, 1, o(4, 0, 0, 1, 2'd0, 0, 1, 0, 1, 0), 16'd4});
        vq.push_back('{0, 0, 4'h1, 0, 0, 0, o(6, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0), 16'd5});
        vq.push_back('{1, 0, 4'hE, 0, 0, 0, o(6, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0), 16'd5});
        vq.push_back('{0, 0, 4'hE, 0, 1, 0, o(1, 1, 1, 0, 2'd0, 0, 0, 0, 1, 0), 16'd5});
        vq.push_back('{0, 0, 4'hE, 0, 0, 0, o(2, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd5});
        vq.push_back('{0, 0, 4'hE, 0, 0, 0, o(3, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd5});
        vq.push_back('{0, 0, 4'hE, 0, 0, 0, o(6, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1), 16'd5});
        vq.push_back('{1, 0, 4'hE, 0, 0, 0, o(6, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1), 16'd5});
        vq.push_back('{0, 0, 4'h0, 0, 0, 0, o(1, 1, 0, 0, 2'd0, 0, 0, 0, 1, 0), 16'd5});

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].start, vq[i].halt_req, vq[i].opcode, vq[i].zero,
                  vq[i].imem_ready, vq[i].dmem_ready);
            #1;
            check($sformatf("row%0d_out", i), act_out(), vq[i].exp_out);
            check($sformatf("row%0d_cnt", i), bus.instr_cnt, vq[i].exp_cnt);
        end

        // Asynchronous reset while fetching, then idle until start
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_fetch_out", act_out(), 13'h0);
        check("rst_fetch_cnt", bus.instr_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 4'h2, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle_hold%0d", i), act_out(), 13'h0);
        end

        // LW with dmem_ready arriving on the fourth MEM cycle
        @(negedge clk);
        drive(1, 0, 4'h0, 0, 1, 0);
        wb_cyc = 0;
        rd_cycles = 0;
        wb_we = 1'b0;
        for (int cyc = 1; cyc <= 20 && wb_cyc == 0; cyc++) begin
            @(negedge clk);
            drive(0, 0, 4'h0, 0, 1, cyc == 7);
            #1;
            if (bus.dmem_rd) rd_cycles++;
            if (bus.state == 3'd5) begin
                wb_cyc = cyc;
                wb_we = bus.rf_we;
            end
        end
        check("lw_dmem_rd_cycles", rd_cycles, 4);
        check("lw_wb_cycle", wb_cyc, 8);
        check("lw_rf_we", {31'd0, wb_we}, 1);
        @(negedge clk);
        #1;
        check("lw_cnt", bus.instr_cnt, 16'd1);

        // Reset while MEM is waiting on dmem_ready
        do_reset();
        drive(1, 0, 4'h0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mem_wait_rd", {29'd0, bus.state, bus.dmem_rd}, {29'd0, 3'd4, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mem_out", act_out(), 13'h0);
        check("rst_mem_cnt", bus.instr_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // JMP with halt_req, then counter wrap on an ALU retiring into HALT
        @(negedge clk);
        drive(1, 1, 4'hD, 0, 1, 0);
        @(negedge clk);
        drive(0, 1, 4'hD, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("jmp_pc_sel", {bus.pc_en, bus.pc_sel}, 3'b110);
        @(negedge clk);
        #1;
        check("jmp_halt_state", bus.state, 3'd6);
        check("jmp_halt_cnt", bus.instr_cnt, 16'd1);
        force dut.r_instr_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_instr_cnt;
        #1;
        check("preload_cnt", bus.instr_cnt, 16'hFFFF);
        drive(1, 0, 4'h2, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 4'h2, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1, 4'h2, 0, 1, 0);
        #1;
        check("wrap_wb_out", act_out(), o(5, 0, 0, 1, 2'd0, 0, 0, 1, 1, 0));
        check("wrap_wb_cnt", bus.instr_cnt, 16'hFFFF);
        @(negedge clk);
        drive(0, 0, 4'h2, 0, 1, 0);
        #1;
        check("wrap_cnt", bus.instr_cnt, 16'h0000);
        check("wrap_halt_out", act_out(), o(6, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
